dram_responder: RTL and testbench
=================================

DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 28, width of the burst base address.
REQ-002 Parameter DATA_WIDTH, default 32, width of one data beat.
REQ-003 Parameter BURST_LEN, default 4, beats per request; power of two, at least 2.
REQ-004 Parameter MEM_DEPTH, default 1024, words of backing storage; power of two.
REQ-005 Parameter RD_LATENCY, default 2, idle cycles between read-address accept and first data beat; at least 1.
REQ-006 clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cntl2ram_a_valid  in  1  address request valid.
REQ-009 cntl2ram_a_ready  out  1  responder can accept an address.
REQ-010 cntl2ram_a_write  in  1  1 = write burst, 0 = read burst.
REQ-011 cntl2ram_a_addr  in  ADDR_WIDTH  burst base word address.
REQ-012 cntl2ram_w_valid  in  1  write beat valid.
REQ-013 cntl2ram_w_ready  out  1  responder accepts a write beat.
REQ-014 cntl2ram_w_data  in  DATA_WIDTH  write beat data.
REQ-015 ram2cntl_r_valid  out  1  read beat valid.
REQ-016 ram2cntl_r_ready  in  1  controller accepts a read beat.
REQ-017 ram2cntl_r_data  out  DATA_WIDTH  read beat data.

Function
REQ-018 A transfer occurs on any channel only in a cycle where valid and ready are both 1.
REQ-019 FSM states are IDLE, WRITE, RWAIT, and READ; the state is IDLE after reset.
REQ-020 cntl2ram_a_ready is 1 only in IDLE; on an address handshake, addr and write are latched, the beat counter is cleared, and the next state is WRITE if write=1, else RWAIT.
REQ-021 In WRITE, cntl2ram_w_ready is 1; each w handshake stores w_data at mem[(base+beat) mod MEM_DEPTH] and increments beat.
REQ-022 After the BURST_LEN-th w handshake, the next state is IDLE; cntl2ram_w_ready is 0 in every other state, and cntl2ram_w_valid is ignored there.
REQ-023 In RWAIT, a latency counter runs for exactly RD_LATENCY cycles, then the state moves to READ, so the first r_valid appears RD_LATENCY+1 cycles after the address-handshake cycle.
REQ-024 In READ, ram2cntl_r_valid is 1 and ram2cntl_r_data equals mem[(base+beat) mod MEM_DEPTH]; both are held stable while ram2cntl_r_ready is 0.
REQ-025 Each r handshake increments beat; after the BURST_LEN-th handshake, r_valid drops and the next state is IDLE.
REQ-026 Address arithmetic uses the low log2(MEM_DEPTH) bits of base+beat, so a burst crossing the top of memory wraps to word 0; upper address bits are ignored.
REQ-027 A read of an address written by an earlier completed burst returns the written data; back-to-back bursts need one IDLE cycle between them.
REQ-028 cntl2ram_a_valid asserted outside IDLE is not accepted and causes no state change; the request is held for the controller.
REQ-029 Only one burst is outstanding at a time; there is no reordering or pipelining of requests.

Reset
REQ-030 While reset=1, a_ready, w_ready, r_valid and r_data are 0, and the state, beat counter and latency counter are cleared.
REQ-031 The first cycle after reset deasserts, the block is in IDLE with a_ready=1.
REQ-032 Reset asserted mid-burst abandons the burst; already-written words are retained and no further beats are consumed or produced.
REQ-033 Memory contents are not initialised by reset.

Verification
REQ-034 Write burst addr=0x10, data 0xA0..0xA3 with w_valid always 1, then read addr=0x10 -> r_data 0xA0,0xA1,0xA2,0xA3; first r_valid 3 cycles after the read-address handshake.
REQ-035 Read with r_ready toggled 1,0,0,1,... -> each beat is held stable until accepted, exactly 4 beats are delivered in order, and a_ready returns 1 the cycle after the last handshake.
REQ-036 Write burst addr=MEM_DEPTH-2, data 1..4 -> words 1022,1023,0,1 hold 1,2,3,4; reading addr=0 returns 3,4,...
REQ-037 w_valid=1 with data 0xFF while in IDLE and RWAIT -> w_ready=0 and memory is unchanged; a_valid held during WRITE is accepted only once IDLE is reached.
REQ-038 Reset asserted after 2 of 4 write beats -> outputs go to 0 and a_ready=1 after release; the first 2 words are written and the last 2 are unchanged.

Source files
------------

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - single-port DRAM model answering fixed-length bursts
//
// Purpose: behavioural-but-synthesizable memory responder. One address request
// starts a BURST_LEN-beat write or read burst; reads return their first beat
// RD_LATENCY+1 cycles after the address handshake. Addresses wrap modulo
// MEM_DEPTH. Only one burst is in flight at a time.
//
// Ports:
//   clock, reset                      sole clock, synchronous active-high reset
//   cntl2ram_a_valid/_ready/_write/_addr   address request channel
//   cntl2ram_w_valid/_ready/_data          write beat channel
//   ram2cntl_r_valid/_ready/_data          read beat channel
module dram_responder #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cntl2ram_a_valid,
  output logic                  cntl2ram_a_ready,
  input  logic                  cntl2ram_a_write,
  input  logic [ADDR_WIDTH-1:0] cntl2ram_a_addr,
  input  logic                  cntl2ram_w_valid,
  output logic                  cntl2ram_w_ready,
  input  logic [DATA_WIDTH-1:0] cntl2ram_w_data,
  output logic                  ram2cntl_r_valid,
  input  logic                  ram2cntl_r_ready,
  output logic [DATA_WIDTH-1:0] ram2cntl_r_data
);

  localparam int IW = $clog2(MEM_DEPTH);
  localparam int BW = $clog2(BURST_LEN);
  localparam int LW = $clog2(RD_LATENCY + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [LW-1:0] LAST_LAT  = LW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WRITE, RWAIT, READ} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         base;
  logic [BW-1:0]         beat;
  logic [LW-1:0]         lat_cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic a_hs, w_hs, r_hs;

  // Only the low IW address bits select a word; the rest are don't-care.
  logic addr_hi_unused;
  assign addr_hi_unused = ^cntl2ram_a_addr[ADDR_WIDTH-1:IW];

  // Sum truncated to IW bits gives the wrap past the top of memory.
  assign idx  = base + IW'(beat);
  assign a_hs = cntl2ram_a_valid & cntl2ram_a_ready;
  assign w_hs = cntl2ram_w_valid & cntl2ram_w_ready;
  assign r_hs = ram2cntl_r_valid & ram2cntl_r_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs are gated by reset so they read 0 for the whole reset cycle,
  // not only after the first reset edge.
  always_comb begin
    state_nxt        = state;
    cntl2ram_a_ready = 1'b0;
    cntl2ram_w_ready = 1'b0;
    ram2cntl_r_valid = 1'b0;
    ram2cntl_r_data  = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          cntl2ram_a_ready = 1'b1;
          if (cntl2ram_a_valid) state_nxt = cntl2ram_a_write ? WRITE : RWAIT;
        end
        WRITE: begin
          cntl2ram_w_ready = 1'b1;
          if (cntl2ram_w_valid && beat == LAST_BEAT) state_nxt = IDLE;
        end
        RWAIT: begin
          if (lat_cnt == LAST_LAT) state_nxt = READ;
        end
        READ: begin
          ram2cntl_r_valid = 1'b1;
          ram2cntl_r_data  = mem[idx];
          if (ram2cntl_r_ready && beat == LAST_BEAT) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Beat counter wraps to 0 on the final beat since BURST_LEN is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      base    <= '0;
      beat    <= '0;
      lat_cnt <= '0;
    end else begin
      if (a_hs) begin
        base    <= cntl2ram_a_addr[IW-1:0];
        beat    <= '0;
        lat_cnt <= '0;
      end else if (w_hs || r_hs) begin
        beat <= beat + 1'b1;
      end
      if (state == RWAIT) lat_cnt <= lat_cnt + 1'b1;
    end
  end

  // Storage has no reset; contents survive a mid-burst reset.
  always_ff @(posedge clock) begin
    if (w_hs) mem[idx] <= cntl2ram_w_data;
  end

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - self-checking bench for dram_responder
module tb_dram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, a_write;
  logic [27:0] a_addr;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic        r_valid, r_ready;
  logic [31:0] r_data;

  dram_responder dut (
    .clock            (clock),
    .reset            (reset),
    .cntl2ram_a_valid (a_valid),
    .cntl2ram_a_ready (a_ready),
    .cntl2ram_a_write (a_write),
    .cntl2ram_a_addr  (a_addr),
    .cntl2ram_w_valid (w_valid),
    .cntl2ram_w_ready (w_ready),
    .cntl2ram_w_data  (w_data),
    .ram2cntl_r_valid (r_valid),
    .ram2cntl_r_ready (r_ready),
    .ram2cntl_r_data  (r_data)
  );

  always #5 clock = ~clock;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  int checks = 0;
  int errors = 0;

  // Reference memory: word contents plus a flag saying it has been written.
  logic [31:0] mem_m [DEPTH];
  bit          known [DEPTH];

  function automatic int widx(input logic [27:0] a, input int b);
    return int'((32'(a) + 32'(b)) % DEPTH);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write burst. gaps: random w_valid bubbles. hold: after the address
  // handshake, present a new read request that must not be taken mid-burst.
  task automatic do_write(input logic [27:0] addr, input logic [3:0][31:0] d,
                          input bit gaps, input bit hold, input logic [27:0] next_addr);
    int beat = 0;
    int cyc  = 0;
    a_valid = 1; a_write = 1; a_addr = addr;
    @(negedge clock);
    chk("wr_a_ready_idle", a_ready, 1);
    chk("wr_w_ready_idle", w_ready, 0);
    @(posedge clock); #1;
    if (hold) begin a_valid = 1; a_write = 0; a_addr = next_addr; end
    else a_valid = 0;
    while (beat < 4 && cyc < 64) begin
      w_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      w_data  = w_valid ? d[beat] : $urandom;
      @(negedge clock);
      chk("wr_w_ready", w_ready, 1);
      if (hold) chk("wr_a_ready_busy", a_ready, 0);
      @(posedge clock);
      if (w_valid) begin
        mem_m[widx(addr, beat)] = d[beat];
        known[widx(addr, beat)] = 1;
        beat++;
      end
      #1; cyc++;
    end
    w_valid = 0;
    chk("wr_done", beat, 4);
  endtask

  // Read burst. rpat supplies r_ready per READ cycle (cyclic, 8 entries);
  // junk drives w_valid=1 with 0xFF throughout, which must be ignored.
  task automatic do_read(input logic [27:0] addr, input logic [3:0][31:0] exp,
                         input logic [3:0] kn, input logic [7:0] rpat, input bit junk);
    int beat = 0;
    int cyc  = 0;
    if (junk) begin w_valid = 1; w_data = 32'hFF; end
    a_valid = 1; a_write = 0; a_addr = addr;
    @(negedge clock);
    chk("rd_a_ready_idle", a_ready, 1);
    if (junk) chk("rd_w_ready_idle", w_ready, 0);
    @(posedge clock); #1;
    a_valid = 0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clock);
      chk("rd_latency_no_valid", r_valid, 0);
      if (junk) chk("rd_w_ready_wait", w_ready, 0);
      @(posedge clock); #1;
    end
    while (beat < 4 && cyc < 64) begin
      r_ready = rpat[cyc % 8];
      @(negedge clock);
      chk("rd_r_valid", r_valid, 1);
      if (kn[beat]) chk("rd_r_data", r_data, exp[beat]);
      if (junk) chk("rd_w_ready_read", w_ready, 0);
      @(posedge clock);
      if (r_ready) beat++;
      #1; cyc++;
    end
    r_ready = 0; w_valid = 0;
    chk("rd_done", beat, 4);
    @(negedge clock);
    chk("rd_r_valid_after", r_valid, 0);
    chk("rd_a_ready_after", a_ready, 1);
    @(posedge clock); #1;
  endtask

  typedef struct {
    bit              wr;
    logic [27:0]     addr;
    logic [3:0][31:0] d;      // write data, or expected read data
    logic [7:0]      rpat;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [3:0][31:0] d, e;
    logic [3:0]       kn;
    logic [27:0]      a, a2;

    reset = 1; a_valid = 0; a_write = 0; a_addr = 0;
    w_valid = 0; w_data = 0; r_ready = 0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    chk("post_rst_a_ready", a_ready, 1);
    @(posedge clock); #1;

    vt[0] = '{1, 28'h10,  {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'hFF};
    vt[1] = '{0, 28'h10,  {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'hFF};
    vt[2] = '{0, 28'h10,  {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h99};
    vt[3] = '{1, 28'h2,   {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 8'hFF};
    vt[4] = '{1, 28'd1022, {32'd4, 32'd3, 32'd2, 32'd1},    8'hFF};
    vt[5] = '{0, 28'd1022, {32'd4, 32'd3, 32'd2, 32'd1},    8'hFF};
    vt[6] = '{0, 28'h0,   {32'hB1, 32'hB0, 32'd4, 32'd3},   8'h5A};
    vt[7] = '{0, 28'hC10, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h33};
    for (int i = 0; i < 8; i++) begin
      if (vt[i].wr) do_write(vt[i].addr, vt[i].d, 0, 0, 0);
      else          do_read(vt[i].addr, vt[i].d, 4'hF, vt[i].rpat, i == 2);
    end

    // Read request held during a write: accepted on the first IDLE cycle.
    d = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    do_write(28'h20, d, 1, 1, 28'h20);
    do_read(28'h20, d, 4'hF, 8'hFF, 0);

    // Reset after 2 of 4 write beats.
    d = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    do_write(28'h30, d, 0, 0, 0);
    a_valid = 1; a_write = 1; a_addr = 28'h30;
    @(negedge clock); @(posedge clock); #1;
    a_valid = 0;
    for (int b = 0; b < 2; b++) begin
      w_valid = 1; w_data = 32'hE0 + b;
      @(negedge clock); @(posedge clock); #1;
    end
    w_data = 32'hE2; reset = 1;
    @(negedge clock);
    chk("midrst_a_ready", a_ready, 0);
    chk("midrst_w_ready", w_ready, 0);
    chk("midrst_r_valid", r_valid, 0);
    chk("midrst_r_data", r_data, 0);
    @(posedge clock); #1;
    reset = 0; w_valid = 0;
    e = {32'hC3, 32'hC2, 32'hE1, 32'hE0};
    mem_m[16'h30] = 32'hE0; mem_m[16'h31] = 32'hE1;
    do_read(28'h30, e, 4'hF, 8'hFF, 0);

    // Randomized bursts against the reference memory.
    for (int i = 0; i < 20; i++) begin
      a = 28'($urandom);
      for (int b = 0; b < 4; b++) d[b] = $urandom;
      do_write(a, d, 1, 0, 0);
      a2 = {4'($urandom), 14'($urandom), 10'(32'(a) + $urandom_range(0, 3))};
      for (int b = 0; b < 4; b++) begin
        e[b]  = mem_m[widx(a2, b)];
        kn[b] = known[widx(a2, b)];
      end
      do_read(a2, e, kn, 8'($urandom) | 8'h01, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
